// File: rtl/sample_readout.sv
// Drains the sample FIFO after capture and serializes each sample into
// little-endian UART bytes, skipping byte lanes the host has masked off.
module sample_readout #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [COUNT_WIDTH-1:0]  sample_count,
    input  logic [3:0]              group_mask,
    input  logic                    fifo_empty,
    input  logic                    fifo_valid,
    input  logic [SAMPLE_WIDTH-1:0] fifo_data,
    output logic                    fifo_rd_en,
    input  logic                    tx_busy,
    output logic                    tx_start,
    output logic [7:0]              tx_byte,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun
);
    // state     | meaning
    // IDLE      | waiting for start
    // FETCH     | request next sample, or flag underrun if FIFO is empty
    // WAIT_DATA | waiting for fifo_valid to capture the sample
    // SELECT    | skip masked lanes; pick next byte or finish the sample
    // SEND      | wait for UART idle, then launch one byte
    // WAIT_ACK  | waiting for UART to report busy
    // WAIT_IDLE | waiting for UART to finish the byte
    // FINISH    | pulse done
    localparam int NUM_BYTES = (SAMPLE_WIDTH + 7) / 8;
    localparam int CAP_W     = NUM_BYTES * 8;
    localparam int IDX_W     = 3;

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_DATA, SELECT, SEND, WAIT_ACK, WAIT_IDLE, FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic [3:0]             mask_q, mask_d;
    logic [CAP_W-1:0]       cap_q, cap_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   rd_en_q, rd_en_d;
    logic                   tx_start_q, tx_start_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   underrun_q, underrun_d;

    logic                   lane_found;
    logic [IDX_W-1:0]       lane_idx;

    // Lowest enabled lane at or above the current byte index.
    always_comb begin
        lane_found = 1'b0;
        lane_idx   = idx_q;
        for (int i = 3; i >= 0; i--) begin
            if (i < NUM_BYTES && i >= int'(idx_q) && !mask_q[i]) begin
                lane_found = 1'b1;
                lane_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        mask_d     = mask_q;
        cap_d      = cap_q;
        idx_d      = idx_q;
        rd_en_d    = 1'b0;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d      = sample_count;
                    mask_d     = group_mask;
                    underrun_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (fifo_empty) begin
                    underrun_d = 1'b1;
                    state_d    = FINISH;
                end else begin
                    rd_en_d = 1'b1;
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (fifo_valid) begin
                    cap_d   = CAP_W'(fifo_data);
                    idx_d   = '0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (lane_found) begin
                    idx_d   = lane_idx;
                    state_d = SEND;
                end else if (rem_q == '0) begin
                    state_d = FINISH;
                end else begin
                    rem_d   = rem_q - COUNT_WIDTH'(1);
                    state_d = FETCH;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_byte_d  = 8'(cap_q >> {idx_q, 3'b000});
                    tx_start_d = 1'b1;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) state_d = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (!tx_busy) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = SELECT;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            idx_q      <= '0;
            rd_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            idx_q      <= idx_d;
            rd_en_q    <= rd_en_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx_start   = tx_start_q;
    assign tx_byte    = tx_byte_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign underrun   = underrun_q;

endmodule

// File: doc/sample_readout.md
Name: sample_readout

Overview:
- Transmit-side counterpart of the command decoder. After capture, it drains the sample FIFO and serializes each sample into UART bytes.
- Channel-group bytes disabled by the host are skipped.
- Sits between sample_fifo and UART_com's transmit port, in parallel with metadata_sender. The controller selects between the two with the data/meta mux.
- The controller pulses start; the block pulses done when finished.

Parameters:
- SAMPLE_WIDTH, 8, sample bits, legal 1..32. Derived NUM_BYTES = ceil(SAMPLE_WIDTH/8).
- COUNT_WIDTH, 16, width of the sample-count input.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin readout; sampled only in IDLE
- sample_count  in  COUNT_WIDTH  samples to send minus one; latched at start
- group_mask  in  4  bit i=1 disables byte i; latched at start; bits >= NUM_BYTES ignored
- fifo_empty  in  1  FIFO has no data
- fifo_valid  in  1  fifo_data valid this cycle
- fifo_data  in  SAMPLE_WIDTH  sample from FIFO
- fifo_rd_en  out  1  one-cycle read request
- tx_busy  in  1  UART transmitter busy
- tx_start  out  1  one-cycle byte-send request
- tx_byte  out  8  byte to transmit
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- underrun  out  1  FIFO ran empty before the count completed; valid with done, held until next start

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). All outputs are registered.
- Reset values: fifo_rd_en=0, tx_start=0, tx_byte=0, busy=0, done=0, underrun=0; FSM goes to IDLE. The remaining count and byte index are cleared.
- FSM states: IDLE, FETCH, WAIT_DATA, SELECT, SEND, WAIT_ACK, WAIT_IDLE, FINISH.
- IDLE: on start, latch sample_count into the remaining-count register and latch group_mask; clear underrun; go to FETCH.
- FETCH:
  - If fifo_empty: set underrun and go to FINISH.
  - Otherwise pulse fifo_rd_en for one cycle and go to WAIT_DATA.
- WAIT_DATA: wait any number of cycles for fifo_valid; capture fifo_data zero-extended to NUM_BYTES*8 bits; set byte index to 0; go to SELECT.
- SELECT:
  - Advance the byte index past masked bytes.
  - If an enabled byte exists at index < NUM_BYTES, go to SEND.
  - Otherwise this sample is complete: if remaining = 0 go to FINISH, else decrement remaining and go to FETCH.
- SEND:
  - If tx_busy=1, hold.
  - Otherwise drive tx_byte = captured[8*idx +: 8], pulse tx_start for one cycle, and go to WAIT_ACK.
- WAIT_ACK: wait for tx_busy=1, then go to WAIT_IDLE.
- WAIT_IDLE: wait for tx_busy=0; increment the byte index; go to SELECT.
- FINISH: pulse done for one cycle; go to IDLE; busy drops the same cycle done is asserted.
- Byte order: little-endian within a sample (bits[7:0] first); samples go out in FIFO order.
- tx_byte is stable from the tx_start cycle until tx_busy falls.
- Latency: start at cycle 0 → fifo_rd_en at cycle 1. First tx_start comes at the earliest 2 cycles after the fifo_valid cycle (SELECT, then SEND).
- Fully masked samples (every byte disabled, or NUM_BYTES with mask all ones) are still read from the FIFO. No tx_start is issued for them, and done still fires after count+1 reads.
- The count is modulo 2^COUNT_WIDTH+1: sample_count = all ones sends 2^COUNT_WIDTH samples. There is no wrap-around beyond that.
- start while not IDLE is ignored. A fifo_valid arriving in any state other than WAIT_DATA is ignored.
- reset mid-operation takes effect on the next edge: FSM to IDLE, all outputs cleared, no further tx_start or fifo_rd_en. A byte already handed to the UART completes on its own.
- start coincident with reset: reset wins.

Test Plan:
1. SAMPLE_WIDTH=8, count=2, mask=0, FIFO holds A5,3C,0F; UART model raises busy 1 cycle after tx_start and holds it 10 cycles → tx_byte sequence A5,3C,0F; exactly 3 fifo_rd_en and 3 tx_start pulses; one done; underrun=0.
2. SAMPLE_WIDTH=32, mask=4'b0101, one sample 0x44332211, count=0 → bytes 22 then 44 only; done after second byte.
3. SAMPLE_WIDTH=12, mask=0, sample 0xABC → bytes BC then 0A (upper nibble zero-padded).
4. Underrun: count=4, FIFO holds 2 entries (11,22) → 2 bytes sent; done with underrun=1; no rd_en issued while fifo_empty.
5. SAMPLE_WIDTH=8, mask=4'b0001, count=1 → 2 fifo_rd_en pulses, 0 tx_start, done pulse.
6. Second start asserted mid-transfer is ignored. reset asserted while in WAIT_IDLE → next cycle busy=0, tx_start=0, fifo_rd_en=0, no done. A subsequent start runs a fresh transfer correctly.
